// File: rtl/floo_vc_credit_allocator_pkg.sv
// floo_vc_credit_allocator_pkg: shared FlooNoC constants and types used by the VC allocator.
package floo_vc_credit_allocator_pkg;

    // Downstream VC input buffer depth; the allocator starts with this many credits per VC.
    localparam int unsigned VCDepthDefault = 3;

    typedef enum logic [2:0] {
        North,
        East,
        South,
        West,
        Eject
    } route_direction_e;

endpackage

// File: rtl/floo_vc_rr_pick.sv
// floo_vc_rr_pick: priority encoder that scans req upward from rr (wrapping) and returns the first hit.
module floo_vc_rr_pick #(
    parameter int unsigned NumVC      = 4,
    parameter int unsigned NumVCWidth = NumVC > 1 ? $clog2(NumVC) : 1
) (
    input  logic [NumVC-1:0]      req,
    input  logic [NumVCWidth-1:0] rr,
    output logic                  v,
    output logic [NumVCWidth-1:0] id
);

    logic [NumVCWidth-1:0] idx;

    always_comb begin
        v   = 1'b0;
        id  = '0;
        idx = '0;
        for (int i = 0; i < NumVC; i++) begin
            idx = NumVCWidth'((int'(rr) + i) % NumVC);
            if (!v && req[idx]) begin
                v  = 1'b1;
                id = idx;
            end
        end
    end

endmodule

// File: rtl/floo_vc_credit_allocator.sv
// floo_vc_credit_allocator: per-output-port VC credit counters, wormhole locks and
// round-robin VC selection for new packet heads.
module floo_vc_credit_allocator
    import floo_vc_credit_allocator_pkg::*;
#(
    parameter int unsigned NumVC       = 4,
    parameter int unsigned NumVCWidth  = NumVC > 1 ? $clog2(NumVC) : 1,
    parameter int unsigned VCDepth     = VCDepthDefault,
    parameter int unsigned CreditWidth = $clog2(VCDepth + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        credit_v_i,
    input  logic [NumVCWidth-1:0]       credit_id_i,
    input  logic                        alloc_v_i,
    input  logic [NumVCWidth-1:0]       alloc_id_i,
    input  logic                        alloc_hdr_i,
    input  logic                        alloc_last_i,
    output logic [NumVC-1:0]            vc_selection_v_o,
    output logic [NumVC*NumVCWidth-1:0] vc_selection_id_o,
    output logic [NumVC-1:0]            vc_credit_avail_o,
    output logic [NumVC-1:0]            vc_locked_o
);

    logic [NumVC-1:0]      avail;
    logic [NumVCWidth-1:0] rr, rr_next;

    for (genvar v = 0; v < NumVC; v++) begin : gen_vc
        logic [CreditWidth-1:0] cnt;
        logic                   lck;
        logic                   ret, con;

        assign ret = credit_v_i && credit_id_i == NumVCWidth'(v);
        assign con = alloc_v_i && alloc_id_i == NumVCWidth'(v);

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt <= CreditWidth'(VCDepth);
                lck <= 1'b0;
            end else begin
                assert (!(con && !ret && cnt == '0));
                assert (!(ret && !con && cnt == CreditWidth'(VCDepth)));
                assert (!(con && alloc_hdr_i && lck));
                assert (!(con && !alloc_hdr_i && !lck));
                // Saturate on illegal traffic instead of wrapping.
                if (ret && !con && cnt != CreditWidth'(VCDepth))
                    cnt <= cnt + 1'b1;
                else if (con && !ret && cnt != '0)
                    cnt <= cnt - 1'b1;
                if (con && (alloc_hdr_i || alloc_last_i))
                    lck <= !alloc_last_i;
            end
        end

        assign avail[v]             = cnt != '0 && !lck;
        assign vc_credit_avail_o[v] = cnt != '0;
        assign vc_locked_o[v]       = lck;
    end

    assign rr_next = alloc_id_i == NumVCWidth'(NumVC - 1) ? '0 : alloc_id_i + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            rr <= '0;
        else if (alloc_v_i && alloc_hdr_i)
            rr <= rr_next;
    end

    for (genvar p = 0; p < NumVC; p++) begin : gen_sel
        logic                  pv;
        logic [NumVCWidth-1:0] pid;

        // The preferred VC is masked so the fallback is always a different VC.
        floo_vc_rr_pick #(
            .NumVC      (NumVC),
            .NumVCWidth (NumVCWidth)
        ) i_pick (
            .req (avail & ~(NumVC'(1) << p)),
            .rr  (rr),
            .v   (pv),
            .id  (pid)
        );

        assign vc_selection_v_o[p] = avail[p] || pv;
        assign vc_selection_id_o[p*NumVCWidth +: NumVCWidth] = avail[p] ? NumVCWidth'(p) : pid;
    end

endmodule

// File: tb/tb_floo_vc_credit_allocator.sv
// tb_floo_vc_credit_allocator: directed plus randomized legal traffic checked against a
// packet-level model of credits, ownership and round-robin VC selection.
module tb_floo_vc_credit_allocator;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       credit_v_i = 1'b0;
    logic [1:0] credit_id_i = '0;
    logic       alloc_v_i = 1'b0;
    logic [1:0] alloc_id_i = '0;
    logic       alloc_hdr_i = 1'b0;
    logic       alloc_last_i = 1'b0;
    logic [3:0] vc_selection_v_o;
    logic [7:0] vc_selection_id_o;
    logic [3:0] vc_credit_avail_o;
    logic [3:0] vc_locked_o;

    int vectors = 0;
    int miscompares = 0;

    int m_cnt [4];
    bit m_lck [4];
    int m_rr;

    floo_vc_credit_allocator dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .credit_v_i        (credit_v_i),
        .credit_id_i       (credit_id_i),
        .alloc_v_i         (alloc_v_i),
        .alloc_id_i        (alloc_id_i),
        .alloc_hdr_i       (alloc_hdr_i),
        .alloc_last_i      (alloc_last_i),
        .vc_selection_v_o  (vc_selection_v_o),
        .vc_selection_id_o (vc_selection_id_o),
        .vc_credit_avail_o (vc_credit_avail_o),
        .vc_locked_o       (vc_locked_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic [3:0] av, e_ca, e_lk;
        logic [1:0] e_id, got_id;
        for (int v = 0; v < 4; v++) begin
            e_ca[v] = m_cnt[v] > 0;
            e_lk[v] = m_lck[v];
            av[v]   = m_cnt[v] > 0 && !m_lck[v];
        end
        vectors++;
        assert (vc_selection_v_o === {4{|av}}) else begin
            miscompares++;
            $error("FAIL %s sel_v got %b exp %b", tag, vc_selection_v_o, {4{|av}});
        end
        vectors++;
        assert (vc_credit_avail_o === e_ca) else begin
            miscompares++;
            $error("FAIL %s credit_avail got %b exp %b", tag, vc_credit_avail_o, e_ca);
        end
        vectors++;
        assert (vc_locked_o === e_lk) else begin
            miscompares++;
            $error("FAIL %s locked got %b exp %b", tag, vc_locked_o, e_lk);
        end
        if (|av) begin
            for (int p = 0; p < 4; p++) begin
                bit found = 0;
                e_id = 2'(p);
                if (!av[p]) begin
                    for (int k = 0; k < 4; k++) begin
                        int w = (m_rr + k) % 4;
                        if (!found && w != p && av[w]) begin
                            found = 1;
                            e_id  = 2'(w);
                        end
                    end
                end
                got_id = vc_selection_id_o[p*2 +: 2];
                vectors++;
                assert (got_id === e_id) else begin
                    miscompares++;
                    $error("FAIL %s sel_id[%0d] got %0d exp %0d", tag, p, got_id, e_id);
                end
            end
        end
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        credit_v_i = 1'b0;
        alloc_v_i = 1'b0;
        @(posedge clk);
        for (int v = 0; v < 4; v++) begin
            m_cnt[v] = 3;
            m_lck[v] = 0;
        end
        m_rr = 0;
        #1;
        rst_i = 1'b0;
        check(tag);
    endtask

    task automatic step(input bit cv, input int cid, input bit av, input int aid,
                        input bit h, input bit l, input string tag);
        credit_v_i   = cv;
        credit_id_i  = 2'(cid);
        alloc_v_i    = av;
        alloc_id_i   = 2'(aid);
        alloc_hdr_i  = h;
        alloc_last_i = l;
        @(posedge clk);
        if (cv) m_cnt[cid]++;
        if (av) begin
            m_cnt[aid]--;
            if (l) m_lck[aid] = 0;
            else if (h) m_lck[aid] = 1;
            if (h) m_rr = (aid + 1) % 4;
        end
        #1;
        check(tag);
    endtask

    initial begin
        do_reset("reset");
        step(0, 0, 0, 0, 0, 0, "idle");
        step(0, 0, 1, 2, 1, 0, "head_vc2");
        step(0, 0, 1, 1, 1, 0, "head_vc1");
        step(0, 0, 1, 1, 0, 0, "body_vc1_a");
        step(0, 0, 1, 1, 0, 0, "body_vc1_b");
        step(1, 1, 0, 0, 0, 0, "credit_vc1");
        step(0, 0, 1, 1, 0, 1, "tail_vc1");
        step(0, 0, 1, 0, 1, 1, "single_vc0_a");
        step(0, 0, 1, 0, 1, 1, "single_vc0_b");
        step(1, 0, 1, 0, 1, 1, "same_cycle_vc0");
        step(0, 0, 1, 0, 1, 1, "single_vc0_c");
        step(0, 0, 1, 3, 1, 0, "head_vc3");
        step(0, 0, 1, 3, 0, 0, "body_vc3_a");
        step(0, 0, 1, 3, 0, 0, "body_vc3_b");
        step(1, 3, 0, 0, 0, 0, "credit_vc3");
        step(0, 0, 1, 3, 0, 1, "tail_vc3_none_avail");
        step(1, 3, 0, 0, 0, 0, "credit_vc3_all_pick3");
        step(1, 0, 0, 0, 0, 0, "credit_vc0");
        step(0, 0, 1, 0, 1, 0, "head_vc0_drain");
        do_reset("mid_packet_reset");
        for (int n = 0; n < 500; n++) begin
            bit cv, avv, h, l;
            int cid, aid;
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rand_reset");
            end else begin
                cv  = 1'($urandom_range(0, 1));
                cid = int'($urandom_range(0, 3));
                if (m_cnt[cid] >= 3) cv = 0;
                avv = 1'($urandom_range(0, 1));
                aid = int'($urandom_range(0, 3));
                if (m_cnt[aid] == 0) avv = 0;
                h = !m_lck[aid];
                l = 1'($urandom_range(0, 1));
                step(cv, cid, avv, aid, h, l, "random");
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
